address_mode_sequencer: RTL and testbench

Parametrised operand/effective-address sequencer for the 6502 core. It takes a decoded addressing mode from the instruction decoder and drives the PC-increment and memory-address controls to fetch operand bytes, index them and dereference pointers. It returns one effective address with a done pulse. It extends the current ZPG/ZPG_X/ABS handling with Y indexing, page-cross timing and all indirect modes.

---
 rtl/address_mode_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_address_mode_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/address_mode_sequencer.sv
// 6502 operand / effective-address sequencer: fetches operand bytes, indexes and
// dereferences pointers, returns ea with a done pulse. Define CMOS_IND_FIX_EN for 65C02 IND.
module address_mode_sequencer #(
  parameter int DATA_W          = 8,
  parameter int STORE_FIX_CYCLE = 1,
  localparam int ADDR_W         = 2*DATA_W
) (
  input  logic              clk,
  input  logic              res,
  input  logic              rdy,
  input  logic              start,
  input  logic [3:0]        mode,
  input  logic              is_store,
  input  logic [DATA_W-1:0] index_x,
  input  logic [DATA_W-1:0] index_y,
  input  logic [DATA_W-1:0] data_in,
  output logic              pc_enable,
  output logic [1:0]        address_select,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] ea,
  output logic              done,
  output logic              busy,
  output logic              page_cross,
  output logic              mode_error
);

  localparam logic [3:0] M_IMP   = 4'd0;
  localparam logic [3:0] M_IMM   = 4'd1;
  localparam logic [3:0] M_ZPG   = 4'd2;
  localparam logic [3:0] M_ZPG_X = 4'd3;
  localparam logic [3:0] M_ZPG_Y = 4'd4;
  localparam logic [3:0] M_ABS   = 4'd5;
  localparam logic [3:0] M_ABS_X = 4'd6;
  localparam logic [3:0] M_ABS_Y = 4'd7;
  localparam logic [3:0] M_IND   = 4'd8;
  localparam logic [3:0] M_IND_X = 4'd9;
  localparam logic [3:0] M_IND_Y = 4'd10;

  localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);
  localparam logic              SFIX = (STORE_FIX_CYCLE != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_LO, S_FETCH_HI, S_INDEX_ADD,
    S_PTR_LO, S_PTR_HI, S_FIX_HI, S_DONE
  } state_t;

  state_t            state, state_n;
  logic [3:0]        mode_q, mode_n;
  logic              store_q, store_n;
  logic [DATA_W-1:0] idx_q, idx_n;
  logic [DATA_W-1:0] lo, lo_n, hi, hi_n;
  logic [DATA_W-1:0] ptr, ptr_n, ptr_hi, ptr_hi_n;
  logic              carry_q, carry_n;
  logic              pcross_q, pcross_n;
  logic              err_q, err_n;
  logic [ADDR_W-1:0] ea_q;
  logic [DATA_W:0]   sum;
  logic              need_fix;
  logic [DATA_W-1:0] ptr_hi_rd;

  assign sum      = {1'b0, lo} + {1'b0, idx_q};
  assign need_fix = sum[DATA_W] | (store_q & SFIX);

`ifdef CMOS_IND_FIX_EN
  // 65C02: the second IND pointer byte carries into the pointer high byte
  assign ptr_hi_rd = (mode_q == M_IND && ptr == '1) ? ptr_hi + ONE : ptr_hi;
`else
  // NMOS: the second pointer byte always wraps within the page
  assign ptr_hi_rd = ptr_hi;
`endif

  always_comb begin
    state_n  = state;
    mode_n   = mode_q;
    store_n  = store_q;
    idx_n    = idx_q;
    lo_n     = lo;
    hi_n     = hi;
    ptr_n    = ptr;
    ptr_hi_n = ptr_hi;
    carry_n  = carry_q;
    pcross_n = pcross_q;
    err_n    = err_q;
    case (state)
      S_IDLE: if (start) begin
        mode_n   = mode;
        store_n  = is_store;
        idx_n    = (mode == M_ZPG_Y || mode == M_ABS_Y || mode == M_IND_Y) ? index_y : index_x;
        lo_n     = '0;
        hi_n     = '0;
        ptr_n    = '0;
        ptr_hi_n = '0;
        carry_n  = 1'b0;
        pcross_n = 1'b0;
        err_n    = (mode > M_IND_Y);
        state_n  = (mode == M_IMP || mode > M_IND_Y) ? S_DONE : S_FETCH_LO;
      end
      S_FETCH_LO: begin
        lo_n  = data_in;
        ptr_n = data_in;
        case (mode_q)
          M_IMM, M_ZPG:            state_n = S_DONE;
          M_ZPG_X, M_ZPG_Y, M_IND_X: state_n = S_INDEX_ADD;
          M_IND_Y:                 state_n = S_PTR_LO;
          default:                 state_n = S_FETCH_HI;
        endcase
      end
      S_FETCH_HI: begin
        hi_n    = data_in;
        state_n = S_DONE;
        if (mode_q == M_IND) begin
          ptr_n    = lo;
          ptr_hi_n = data_in;
          state_n  = S_PTR_LO;
        end else if (mode_q == M_ABS_X || mode_q == M_ABS_Y) begin
          lo_n     = sum[DATA_W-1:0];
          carry_n  = sum[DATA_W];
          pcross_n = sum[DATA_W];
          state_n  = need_fix ? S_FIX_HI : S_DONE;
        end
      end
      S_INDEX_ADD: begin
        // zero-page indexing: carry is discarded
        lo_n    = sum[DATA_W-1:0];
        ptr_n   = sum[DATA_W-1:0];
        state_n = (mode_q == M_IND_X) ? S_PTR_LO : S_DONE;
      end
      S_PTR_LO: begin
        lo_n    = data_in;
        state_n = S_PTR_HI;
      end
      S_PTR_HI: begin
        hi_n    = data_in;
        state_n = S_DONE;
        if (mode_q == M_IND_Y) begin
          lo_n     = sum[DATA_W-1:0];
          carry_n  = sum[DATA_W];
          pcross_n = sum[DATA_W];
          state_n  = need_fix ? S_FIX_HI : S_DONE;
        end
      end
      S_FIX_HI: begin
        hi_n    = hi + {{(DATA_W-1){1'b0}}, carry_q};
        state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state    <= S_IDLE;
      mode_q   <= '0;
      store_q  <= 1'b0;
      idx_q    <= '0;
      lo       <= '0;
      hi       <= '0;
      ptr      <= '0;
      ptr_hi   <= '0;
      carry_q  <= 1'b0;
      pcross_q <= 1'b0;
      err_q    <= 1'b0;
      ea_q     <= '0;
    end else if (rdy) begin
      state    <= state_n;
      mode_q   <= mode_n;
      store_q  <= store_n;
      idx_q    <= idx_n;
      lo       <= lo_n;
      hi       <= hi_n;
      ptr      <= ptr_n;
      ptr_hi   <= ptr_hi_n;
      carry_q  <= carry_n;
      pcross_q <= pcross_n;
      err_q    <= err_n;
      if (state_n == S_DONE && state != S_DONE)
        ea_q <= err_n ? '0 : {hi_n, lo_n};
    end
  end

  always_comb begin
    mem_addr = '0;
    case (state)
      S_PTR_LO: mem_addr = {ptr_hi, ptr};
      S_PTR_HI: mem_addr = {ptr_hi_rd, ptr + ONE};
      default:  mem_addr = '0;
    endcase
  end

  assign pc_enable      = rdy & (state == S_FETCH_LO || state == S_FETCH_HI);
  assign address_select = (state == S_PTR_LO || state == S_PTR_HI) ? 2'd1 : 2'd0;
  assign done           = (state == S_DONE);
  assign busy           = (state != S_IDLE);
  assign ea             = ea_q;
  assign page_cross     = pcross_q;
  assign mode_error     = err_q;

endmodule

// File: tb/tb_address_mode_sequencer.sv
// Directed, table-driven bench for address_mode_sequencer with a byte-memory and PC model.
module tb_address_mode_sequencer;
  logic        clk = 1'b0;
  logic        res, rdy, start, is_store;
  logic [3:0]  mode;
  logic [7:0]  index_x, index_y, data_in;
  logic        pc_enable, done, busy, page_cross, mode_error;
  logic [1:0]  address_select;
  logic [15:0] mem_addr, ea;

  logic [7:0]  mem [0:65535];
  logic [15:0] pc = 16'h0200;

  int checks = 0;
  int failures = 0;

  address_mode_sequencer #(.DATA_W(8), .STORE_FIX_CYCLE(1)) dut (
    .clk(clk), .res(res), .rdy(rdy), .start(start), .mode(mode),
    .is_store(is_store), .index_x(index_x), .index_y(index_y),
    .data_in(data_in), .pc_enable(pc_enable), .address_select(address_select),
    .mem_addr(mem_addr), .ea(ea), .done(done), .busy(busy),
    .page_cross(page_cross), .mode_error(mode_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (pc_enable) pc <= pc + 16'd1;

  assign data_in = (address_select == 2'd1) ? mem[mem_addr] : mem[pc];

  typedef struct {
    logic [3:0]  mode;
    logic        st;
    logic [7:0]  x, y, b0, b1;
    logic [15:0] a0, a1, a2;
    logic [7:0]  d0, d1, d2;
    logic [15:0] ea;
    logic        pcr, me;
    int          lat, pce;
  } vec_t;

  vec_t vt [17];

  function automatic vec_t mk(input logic [3:0] m, input logic st, input logic [7:0] x, y, b0, b1,
                              input logic [15:0] a0, input logic [7:0] d0,
                              input logic [15:0] a1, input logic [7:0] d1,
                              input logic [15:0] a2, input logic [7:0] d2,
                              input logic [15:0] e, input logic pcr, me, input int lat, pce);
    vec_t v;
    v.mode = m; v.st = st; v.x = x; v.y = y; v.b0 = b0; v.b1 = b1;
    v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1; v.a2 = a2; v.d2 = d2;
    v.ea = e; v.pcr = pcr; v.me = me; v.lat = lat; v.pce = pce;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Called at a negedge just after accept; counts cycles until done (bounded).
  task automatic wait_done(input string nm, output int lat, output int pce, output bit got);
    lat = 1; pce = 0; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pc_enable) pce++;
      if (done) begin got = 1'b1; break; end
      @(negedge clk);
      lat++;
    end
    if (!got) begin
      failures++;
      checks++;
      $display("FAIL %s_timeout actual=no_done required=done", nm);
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int lat, pce;
    bit got;
    mem[pc] = v.b0; mem[pc + 16'd1] = v.b1;
    mem[v.a0] = v.d0; mem[v.a1] = v.d1; mem[v.a2] = v.d2;
    index_x = v.x; index_y = v.y; mode = v.mode; is_store = v.st;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done($sformatf("v%0d", n), lat, pce, got);
    if (got) begin
      chk($sformatf("v%0d_ea", n), 32'(ea), 32'(v.ea));
      chk($sformatf("v%0d_page_cross", n), 32'(page_cross), 32'(v.pcr));
      chk($sformatf("v%0d_mode_error", n), 32'(mode_error), 32'(v.me));
      chk($sformatf("v%0d_latency", n), 32'(lat), 32'(v.lat));
      chk($sformatf("v%0d_pc_pulses", n), 32'(pce), 32'(v.pce));
    end
    @(negedge clk);
  endtask

  localparam logic [15:0] NA = 16'hEEEE;
`ifdef CMOS_IND_FIX_EN
  localparam logic [15:0] IND_EA = 16'h6080;
`else
  localparam logic [15:0] IND_EA = 16'h5080;
`endif

  initial begin
    int lat, pce;
    bit got;
    //            mode  st x      y      b0     b1     pointer memory writes                       ea        pc me lat pce
    vt[0]  = mk(4'd0,  0, 8'h00, 8'h00, 8'h00, 8'h00, NA, 0, NA, 0, NA, 0,                        16'h0000, 0, 0, 1, 0);
    vt[1]  = mk(4'd1,  0, 8'h00, 8'h00, 8'h42, 8'h00, NA, 0, NA, 0, NA, 0,                        16'h0042, 0, 0, 2, 1);
    vt[2]  = mk(4'd2,  0, 8'h00, 8'h00, 8'h37, 8'h00, NA, 0, NA, 0, NA, 0,                        16'h0037, 0, 0, 2, 1);
    vt[3]  = mk(4'd3,  0, 8'h20, 8'h00, 8'hF0, 8'h00, NA, 0, NA, 0, NA, 0,                        16'h0010, 0, 0, 3, 1);
    vt[4]  = mk(4'd4,  0, 8'h00, 8'h90, 8'h80, 8'h00, NA, 0, NA, 0, NA, 0,                        16'h0010, 0, 0, 3, 1);
    vt[5]  = mk(4'd5,  0, 8'h00, 8'h00, 8'h34, 8'h12, NA, 0, NA, 0, NA, 0,                        16'h1234, 0, 0, 3, 2);
    vt[6]  = mk(4'd7,  0, 8'h00, 8'h01, 8'hFF, 8'h12, NA, 0, NA, 0, NA, 0,                        16'h1300, 1, 0, 4, 2);
    vt[7]  = mk(4'd7,  0, 8'h00, 8'h00, 8'hFF, 8'h12, NA, 0, NA, 0, NA, 0,                        16'h12FF, 0, 0, 3, 2);
    vt[8]  = mk(4'd7,  1, 8'h00, 8'h00, 8'hFF, 8'h12, NA, 0, NA, 0, NA, 0,                        16'h12FF, 0, 0, 4, 2);
    vt[9]  = mk(4'd6,  0, 8'h01, 8'h00, 8'hFF, 8'hFF, NA, 0, NA, 0, NA, 0,                        16'h0000, 1, 0, 4, 2);
    vt[10] = mk(4'd6,  0, 8'h05, 8'h77, 8'h10, 8'h20, NA, 0, NA, 0, NA, 0,                        16'h2015, 0, 0, 3, 2);
    vt[11] = mk(4'd8,  0, 8'h00, 8'h00, 8'hFF, 8'h30, 16'h30FF, 8'h80, 16'h3000, 8'h50, 16'h3100, 8'h60, IND_EA, 0, 0, 5, 2);
    vt[12] = mk(4'd9,  0, 8'h01, 8'h00, 8'hFE, 8'h00, 16'h00FF, 8'h34, 16'h0000, 8'h12, 16'h0100, 8'h99, 16'h1234, 0, 0, 5, 1);
    vt[13] = mk(4'd10, 0, 8'h00, 8'h20, 8'h40, 8'h00, 16'h0040, 8'hF0, 16'h0041, 8'h20, NA, 0,     16'h2110, 1, 0, 5, 1);
    vt[14] = mk(4'd10, 0, 8'h00, 8'h05, 8'h50, 8'h00, 16'h0050, 8'h10, 16'h0051, 8'h33, NA, 0,     16'h3315, 0, 0, 4, 1);
    vt[15] = mk(4'd12, 0, 8'h00, 8'h00, 8'h00, 8'h00, NA, 0, NA, 0, NA, 0,                        16'h0000, 0, 1, 1, 0);
    vt[16] = mk(4'd15, 0, 8'h00, 8'h00, 8'h00, 8'h00, NA, 0, NA, 0, NA, 0,                        16'h0000, 0, 1, 1, 0);

    res = 1'b1; rdy = 1'b1; start = 1'b0; mode = 4'd0; is_store = 1'b0;
    index_x = 8'h00; index_y = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {14'd0, done, busy, page_cross, mode_error, pc_enable, address_select, mem_addr, ea},
        32'd0);
    res = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 17; i++) run_vec(vt[i], i);

    // rdy stall in FETCH_HI of ABS_X
    mem[pc] = 8'h10; mem[pc + 16'd1] = 8'h20;
    index_x = 8'h05; mode = 4'd6; is_store = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("stall_fetch_lo_pce", 32'(pc_enable), 32'd1);
    @(negedge clk);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d_pce", i), 32'(pc_enable), 32'd0);
      chk($sformatf("stall%0d_busy_done", i), {30'd0, busy, done}, 32'd2);
      @(negedge clk);
    end
    rdy = 1'b1;
    #1;
    chk("stall_resume_pce", 32'(pc_enable), 32'd1);
    @(negedge clk);
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_ea", 32'(ea), 32'h2015);
    @(negedge clk);

    // reset asserted while in PTR_LO of IND
    mem[pc] = 8'hFF; mem[pc + 16'd1] = 8'h30;
    mode = 4'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (address_select == 2'd1) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("ptr_lo_reached", 32'(got), 32'd1);
    chk("ptr_lo_addr", 32'(mem_addr), 32'h30FF);
    res = 1'b1;
    @(negedge clk);
    chk("midrun_reset_outputs", {14'd0, done, busy, page_cross, mode_error, pc_enable, address_select, mem_addr, ea},
        32'd0);
    res = 1'b0;
    @(negedge clk);

    // index sampled at accept only
    mem[pc] = 8'hF0; index_x = 8'h20; mode = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    index_x = 8'h55;
    wait_done("idx_latch", lat, pce, got);
    if (got) begin
      chk("idx_latch_ea", 32'(ea), 32'h0010);
      chk("idx_latch_lat", 32'(lat), 32'd3);
    end
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
